tcounter_presc: RTL and testbench
=================================

TCOUNTER_PRESC -- requirements
Module: tcounter_presc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter/compare width (legal 2..64).
REQ-002 SHALL have parameter PRESC_W, default 8, prescaler field width (legal 1..16).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable_count_i  input  1  counting enable, level.
REQ-006 SHALL have port reset_count_i  input  1  synchronous clear of counter and prescaler.
REQ-007 SHALL have port write_counter_i  input  1  synchronous load strobe.
REQ-008 SHALL have port counter_value_i  input  WIDTH  value to load.
REQ-009 SHALL have port compare_value_i  input  WIDTH  compare/reload value.
REQ-010 SHALL have port prescaler_i  input  PRESC_W  tick every prescaler_i+1 enabled cycles.
REQ-011 SHALL have port mode_i  input  2  00 free-run up, 01 up auto-clear, 10 one-shot up, 11 down auto-reload.
REQ-012 SHALL have port counter_value_o  output  WIDTH  counter register.
REQ-013 SHALL have port target_reached_o  output  1  registered one-cycle match-event pulse.
REQ-014 SHALL have port target_greater_o  output  1  combinational counter_value_o > compare_value_i (unsigned).
REQ-015 SHALL have port running_o  output  1  high when FSM is RUN.

Function
REQ-016 SHALL hold prescaler count pcnt (PRESC_W bits); tick = (state==RUN) & enable_count_i & (pcnt==prescaler_i).
REQ-017 SHALL, in RUN with enable high, set pcnt to 0 on tick else pcnt+1; pcnt SHALL hold otherwise.
REQ-018 SHALL treat match as tick & (cnt==compare_value_i) for modes 00/01/10, tick & (cnt==0) for mode 11.
REQ-019 SHALL on tick update cnt: mode 00 cnt+1 (wrap all-ones->0); mode 01 match?0:cnt+1; mode 10 match?hold:cnt+1; mode 11 match?compare_value_i:cnt-1.
REQ-020 SHALL assert target_reached_o exactly one cycle, the cycle after the match edge.
REQ-021 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN when enable_count_i=1; RUN->IDLE when enable_count_i=0.
REQ-022 SHALL move RUN->DONE on mode-10 match; DONE SHALL ignore enable_count_i and ticks.
REQ-023 SHALL leave DONE only on reset_count_i or write_counter_i, to RUN if enable_count_i=1 else IDLE.
REQ-024 SHALL give priority reset_count_i > write_counter_i > tick in any cycle.
REQ-025 SHALL on reset_count_i set cnt=0, pcnt=0, suppress match/pulse that cycle.
REQ-026 SHALL on write_counter_i set cnt=counter_value_i, pcnt=0, suppress match/pulse that cycle.
REQ-027 SHALL sample mode_i, compare_value_i, prescaler_i every cycle; mid-run changes take effect at next tick.
REQ-028 SHALL, if prescaler_i drops below pcnt, continue counting pcnt up and wrap at 2^PRESC_W before ticking (no forced tick).
REQ-029 SHALL with prescaler_i=0 tick every enabled RUN cycle.

Reset
REQ-030 SHALL on rst_i=1 asynchronously force cnt=0, pcnt=0, state=IDLE, target_reached_o=0, running_o=0.
REQ-031 SHALL resume normal operation on the first rising clk_i edge after rst_i deasserts; reset mid-count discards all progress.

Verification
REQ-032 Mode 00, prescaler 0, compare 5, enable from cnt 0 -> cnt 1,2,...; target_reached_o pulse cycle after cnt==5 edge; counting continues to 6.
REQ-033 Mode 01, prescaler 3, compare 2 -> cnt changes every 4 cycles, sequence 0,1,2,0,1,2; pulse each return to 0; target_greater_o never set.
REQ-034 Mode 10, compare 3 -> cnt stops at 3, running_o=0, one pulse; enable toggling no effect; write_counter_i with 0 and enable=1 restarts.
REQ-035 Mode 11, compare 4, load 2 -> 2,1,0,4,3,...; pulse when reloading from 0; WIDTH=8 mode 00 from 0xFF wraps to 0x00.
REQ-036 reset_count_i and write_counter_i same cycle -> cnt=0; rst_i pulsed mid-count at cnt 7 -> cnt=0, IDLE, no pulse, restart from 0.

Source files
------------

// File: rtl/tcounter_presc.sv
// tcounter_presc -- prescaled timer/counter with compare, four counting modes
// and a small IDLE/RUN/DONE sequencer.
//
// The prescaler divides enabled RUN cycles so that the counter advances once
// every prescaler_i+1 of them ("tick"). On each tick the counter moves
// according to mode_i and may raise a match event, reported one cycle later
// as a single-cycle pulse on target_reached_o.
//
// Ports:
//   clk_i             clock, all state on rising edge
//   rst_i             asynchronous active-high reset
//   enable_count_i    counting enable (level)
//   reset_count_i     synchronous clear of counter and prescaler (highest priority)
//   write_counter_i   synchronous load of counter_value_i
//   counter_value_i   value loaded by write_counter_i
//   compare_value_i   compare value (modes 00/01/10) or reload value (mode 11)
//   prescaler_i       tick every prescaler_i+1 enabled RUN cycles
//   mode_i            00 free-run up, 01 up auto-clear, 10 one-shot up,
//                     11 down auto-reload
//   counter_value_o   counter register
//   target_reached_o  registered one-cycle match pulse
//   target_greater_o  counter_value_o > compare_value_i (unsigned, combinational)
//   running_o         high while the sequencer is in RUN
module tcounter_presc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_count_i,
  input  logic               reset_count_i,
  input  logic               write_counter_i,
  input  logic [WIDTH-1:0]   counter_value_i,
  input  logic [WIDTH-1:0]   compare_value_i,
  input  logic [PRESC_W-1:0] prescaler_i,
  input  logic [1:0]         mode_i,
  output logic [WIDTH-1:0]   counter_value_o,
  output logic               target_reached_o,
  output logic               target_greater_o,
  output logic               running_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               pulse_q, pulse_d;
  logic               running_q, running_d;

  logic in_run_s;
  logic tick_s;
  logic cmp_hit_s;
  logic match_s;

  assign in_run_s = (state_q == ST_RUN);

  // Exact equality only: if prescaler_i drops below pcnt, pcnt keeps counting
  // and wraps around before the next tick instead of forcing one.
  assign tick_s = in_run_s & enable_count_i & (pcnt_q == prescaler_i);

  // Compare condition: down-counting mode matches on zero, others on compare value.
  always_comb begin
    cmp_hit_s = 1'b0;
    if (mode_i == 2'b11) begin
      cmp_hit_s = (cnt_q == '0);
    end else begin
      cmp_hit_s = (cnt_q == compare_value_i);
    end
  end

  // Clear and load take the cycle, so no match may be reported on it.
  assign match_s = tick_s & cmp_hit_s & ~reset_count_i & ~write_counter_i;

  // Counter and prescaler next state with clear > load > tick priority.
  always_comb begin
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    if (reset_count_i) begin
      cnt_d  = '0;
      pcnt_d = '0;
    end else if (write_counter_i) begin
      cnt_d  = counter_value_i;
      pcnt_d = '0;
    end else if (in_run_s && enable_count_i) begin
      if (tick_s) begin
        pcnt_d = '0;
        case (mode_i)
          2'b00:   cnt_d = cnt_q + CNT_ONE;
          2'b01:   cnt_d = cmp_hit_s ? '0 : (cnt_q + CNT_ONE);
          2'b10:   cnt_d = cmp_hit_s ? cnt_q : (cnt_q + CNT_ONE);
          2'b11:   cnt_d = cmp_hit_s ? compare_value_i : (cnt_q - CNT_ONE);
          default: cnt_d = cnt_q;
        endcase
      end else begin
        pcnt_d = pcnt_q + PRESC_ONE;
      end
    end else begin
      cnt_d  = cnt_q;
      pcnt_d = pcnt_q;
    end
  end

  // Sequencer next state; DONE is left only through clear or load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_count_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable_count_i) begin
          state_d = ST_IDLE;
        end else if (match_s && (mode_i == 2'b10)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (reset_count_i || write_counter_i) begin
          state_d = enable_count_i ? ST_RUN : ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register next values derived from the transition being taken.
  always_comb begin
    pulse_d   = match_s;
    running_d = (state_d == ST_RUN);
  end

  // State, counter, prescaler and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
    end
  end

  assign counter_value_o  = cnt_q;
  assign target_reached_o = pulse_q;
  assign running_o        = running_q;
  assign target_greater_o = (cnt_q > compare_value_i);

endmodule

// File: tb/tb_tcounter_presc.sv
// Testbench for tcounter_presc (WIDTH=8, PRESC_W=4): a vector table for the
// basic counting modes, hand-written sequences for one-shot, down-reload,
// wrap, prescaler shrink and async reset, then randomized stimulus against a
// behavioural model.
module tb_tcounter_presc;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, rc, wr;
  logic [7:0] cv, cmp;
  logic [3:0] presc;
  logic [1:0] mode;
  logic [7:0] cnt_o;
  logic       pulse_o, gt_o, run_o;

  int total = 0;
  int bad   = 0;

  // behavioural model: counter value, prescale phase, phase name, pending pulse
  int m_cnt;
  int m_pc;
  int m_phase; // 0 idle, 1 counting, 2 finished one-shot
  bit m_pulse;

  tcounter_presc #(.WIDTH(8), .PRESC_W(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .enable_count_i   (en),
    .reset_count_i    (rc),
    .write_counter_i  (wr),
    .counter_value_i  (cv),
    .compare_value_i  (cmp),
    .prescaler_i      (presc),
    .mode_i           (mode),
    .counter_value_o  (cnt_o),
    .target_reached_o (pulse_o),
    .target_greater_o (gt_o),
    .running_o        (run_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rc, wr, en;
    bit [1:0] mode;
    bit [3:0] presc;
    bit [7:0] cmp, cv;
    bit [7:0] e_cnt;
    bit       e_pulse, e_run, e_gt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit r, bit w, bit e, bit [1:0] md, bit [3:0] p,
                              bit [7:0] c, bit [7:0] v, bit [7:0] ec,
                              bit ep, bit er, bit eg);
    vec_t x;
    x.rc = r; x.wr = w; x.en = e; x.mode = md; x.presc = p; x.cmp = c; x.cv = v;
    x.e_cnt = ec; x.e_pulse = ep; x.e_run = er; x.e_gt = eg;
    return x;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pc = 0; m_phase = 0; m_pulse = 1'b0;
  endtask

  // One clock edge of the model, computed from the current inputs.
  task automatic model_edge();
    bit live, tk, hit;
    live = (m_phase == 1);
    tk   = live && en && (m_pc == int'(presc));
    hit  = tk && ((mode == 2'd3) ? (m_cnt == 0) : (m_cnt == int'(cmp)));
    if (rc) begin
      hit = 1'b0; m_cnt = 0; m_pc = 0;
    end else if (wr) begin
      hit = 1'b0; m_cnt = int'(cv); m_pc = 0;
    end else if (live && en) begin
      if (!tk) begin
        m_pc = (m_pc + 1) % 16;
      end else begin
        m_pc = 0;
        if (mode == 2'd0) m_cnt = (m_cnt + 1) % 256;
        else if (mode == 2'd1) m_cnt = hit ? 0 : (m_cnt + 1) % 256;
        else if (mode == 2'd2) m_cnt = hit ? m_cnt : (m_cnt + 1) % 256;
        else m_cnt = hit ? int'(cmp) : m_cnt - 1;
      end
    end
    if (m_phase == 0) m_phase = en ? 1 : 0;
    else if (m_phase == 1) m_phase = !en ? 0 : ((hit && mode == 2'd2) ? 2 : 1);
    else if (rc || wr) m_phase = en ? 1 : 0;
    m_pulse = hit;
  endtask

  task automatic drive(bit r, bit w, bit e, bit [1:0] md, bit [3:0] p,
                       bit [7:0] c, bit [7:0] v);
    rc = r; wr = w; en = e; mode = md; presc = p; cmp = c; cv = v;
  endtask

  // Advance one cycle and compare all outputs to the model.
  task automatic step(string nm);
    model_edge();
    @(posedge clk);
    #1;
    chk({nm, "_cnt"},   cnt_o,   m_cnt[7:0]);
    chk({nm, "_pulse"}, pulse_o, m_pulse);
    chk({nm, "_run"},   run_o,   m_phase == 1);
    chk({nm, "_gt"},    gt_o,    m_cnt > int'(cmp));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 2'd0, 4'd0, 8'd0, 8'd0);
    model_reset();
    #12;
    chk("rst_cnt", cnt_o, 8'd0);
    chk("rst_pulse", pulse_o, 1'b0);
    chk("rst_run", run_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // free-run up, prescaler 0, compare 5
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd0,0,1,0));
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd1,0,1,0));
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd2,0,1,0));
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd3,0,1,0));
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd4,0,1,0));
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd5,0,1,0));
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd6,1,1,1));
    vt.push_back(mk(0,0,1,2'd0,4'd0,8'd5,8'd0, 8'd7,0,1,1));
    // clear and load together: clear wins
    vt.push_back(mk(1,1,1,2'd0,4'd0,8'd5,8'd9, 8'd0,0,1,0));
    vt.push_back(mk(0,0,0,2'd0,4'd0,8'd5,8'd9, 8'd0,0,0,0));
    // up auto-clear, prescaler 3, compare 2
    vt.push_back(mk(0,0,1,2'd1,4'd3,8'd2,8'd0, 8'd0,0,1,0));
    for (int k = 0; k < 3; k++) vt.push_back(mk(0,0,1,2'd1,4'd3,8'd2,8'd0, 8'd0,0,1,0));
    for (int k = 0; k < 4; k++) vt.push_back(mk(0,0,1,2'd1,4'd3,8'd2,8'd0, 8'd1,0,1,0));
    for (int k = 0; k < 4; k++) vt.push_back(mk(0,0,1,2'd1,4'd3,8'd2,8'd0, 8'd2,0,1,0));
    vt.push_back(mk(0,0,1,2'd1,4'd3,8'd2,8'd0, 8'd0,1,1,0));
    vt.push_back(mk(0,0,1,2'd1,4'd3,8'd2,8'd0, 8'd0,0,1,0));

    foreach (vt[i]) begin
      drive(vt[i].rc, vt[i].wr, vt[i].en, vt[i].mode, vt[i].presc, vt[i].cmp, vt[i].cv);
      model_edge();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt", i),   cnt_o,   vt[i].e_cnt);
      chk($sformatf("vec%0d_pulse", i), pulse_o, vt[i].e_pulse);
      chk($sformatf("vec%0d_run", i),   run_o,   vt[i].e_run);
      chk($sformatf("vec%0d_gt", i),    gt_o,    vt[i].e_gt);
    end

    // one-shot, compare 3
    drive(1, 0, 1, 2'd2, 4'd0, 8'd3, 8'd0); step("os_clr");
    rc = 1'b0;
    for (int k = 0; k < 3; k++) step("os_up");
    step("os_hit");
    chk("os_stop_cnt", cnt_o, 8'd3);
    chk("os_stop_pulse", pulse_o, 1'b1);
    chk("os_stop_run", run_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      en = k[0];
      step("os_done");
    end
    chk("os_hold_cnt", cnt_o, 8'd3);
    chk("os_hold_run", run_o, 1'b0);
    drive(0, 1, 1, 2'd2, 4'd0, 8'd3, 8'd0); step("os_restart");
    chk("os_restart_run", run_o, 1'b1);
    wr = 1'b0; step("os_again");
    chk("os_again_cnt", cnt_o, 8'd1);

    // down auto-reload: load 2, reload value 4
    drive(0, 1, 1, 2'd3, 4'd0, 8'd4, 8'd2); step("dn_load");
    wr = 1'b0;
    step("dn_1"); step("dn_0"); step("dn_reload");
    chk("dn_reload_cnt", cnt_o, 8'd4);
    chk("dn_reload_pulse", pulse_o, 1'b1);
    step("dn_3");
    chk("dn_3_cnt", cnt_o, 8'd3);
    chk("dn_3_pulse", pulse_o, 1'b0);

    // 8-bit wrap in free-run
    drive(0, 1, 1, 2'd0, 4'd0, 8'h10, 8'hFF); step("wrap_load");
    wr = 1'b0; step("wrap");
    chk("wrap_cnt", cnt_o, 8'h00);

    // prescaler shrinks below the running phase: no forced tick, wraps first
    drive(1, 0, 1, 2'd0, 4'd10, 8'h80, 8'd0); step("pw_clr");
    rc = 1'b0;
    for (int k = 0; k < 8; k++) step("pw_a");
    presc = 4'd2;
    for (int k = 0; k < 10; k++) step("pw_b");
    chk("pw_before_cnt", cnt_o, 8'd0);
    step("pw_tick");
    chk("pw_tick_cnt", cnt_o, 8'd1);

    // asynchronous reset in the middle of a count at 7, compare 7
    drive(1, 0, 1, 2'd0, 4'd0, 8'd7, 8'd0); step("ar_clr");
    rc = 1'b0;
    for (int k = 0; k < 7; k++) step("ar_up");
    chk("ar_pre_cnt", cnt_o, 8'd7);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar_async_cnt", cnt_o, 8'd0);
    chk("ar_async_run", run_o, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_hold_pulse", pulse_o, 1'b0);
    chk("ar_hold_cnt", cnt_o, 8'd0);
    rst = 1'b0;
    step("ar_idle_run");
    chk("ar_restart_cnt0", cnt_o, 8'd0);
    step("ar_count");
    chk("ar_restart_cnt1", cnt_o, 8'd1);

    // randomized stimulus against the model
    for (int k = 0; k < 2000; k++) begin
      rc = ($urandom_range(0, 31) == 0);
      wr = ($urandom_range(0, 23) == 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        presc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) cmp = 8'($urandom_range(0, 12));
      cv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 10));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
